// File: rtl/divide_control.sv
// Sequencer for a restoring shift-subtract divider: one load, WIDTH shift/subtract
// iterations, then Ready held until Run drops. A zero divisor skips iteration.
//
// state | meaning
// IDLE  | waiting for Run; Div_zero sampled here only
// LOAD  | dividend into Rem_lo, Rem_hi cleared
// SHIFT | Rem/Quo register shifted left by one
// SUB   | trial subtract; write-back and quotient bit when the difference is >= 0
// DONE  | result (or divide-by-zero flag) valid until Run drops
module divide_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Div_zero,
  input  logic             Rem_sign,
  output logic             Load_ctrl,
  output logic             SLL_ctrl,
  output logic             Sub_ctrl,
  output logic             W_ctrl,
  output logic             Q_set,
  output logic             Busy,
  output logic             Ready,
  output logic             Dz_flag,
  output logic [CNT_W-1:0] Iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
          if (Div_zero) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = LOAD;
            dz_d    = 1'b0;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = Run ? SHIFT : IDLE;
      end
      SHIFT: begin
        if (!Run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
        if (!Run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == LAST_CNT) ? DONE : SHIFT;
        end
      end
      DONE: begin
        if (!Run) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Write-back is suppressed when Run drops in SUB so an aborted pass leaves Rem_hi untouched.
  assign Load_ctrl  = (state_q == LOAD);
  assign SLL_ctrl   = (state_q == SHIFT);
  assign Sub_ctrl   = (state_q == SUB);
  assign W_ctrl     = (state_q == SUB) & ~Rem_sign & Run;
  assign Q_set      = W_ctrl;
  assign Busy       = (state_q == LOAD) | (state_q == SHIFT) | (state_q == SUB);
  assign Ready      = (state_q == DONE);
  assign Dz_flag    = dz_q;
  assign Iter_count = cnt_q;

endmodule
